// File: rtl/safe_pkg.sv
// Shared encoding package for the keypad front end and the safe controller.
// Both ends import it so the key code values and the scanner state names
// are defined in exactly one place.
//   KEY_NONE  : idle code, present on key_code whenever no key event is issued
//   KEY_ENTER : '#' key
//   KEY_STAR  : '*' key
//   scan_state_t : scanner FSM states
//   key_map(row, col) : physical key position -> 4-bit key code
package safe_pkg;

  localparam logic [3:0] KEY_NONE  = 4'd13;
  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Row 0 is the top row. Rows 0-2 hold the digits 1-9 in reading order,
  // row 3 holds '*', '0', '#'.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_ENTER;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle of the keypad scanner.
//   row_n     : raw active-low keypad rows (asynchronous to clk)
//   col_n     : one-hot active-low column drive
//   key_code  : registered key code, KEY_NONE when idle
//   key_valid : one-cycle key event strobe
//   state     : scanner FSM state, exported for observation only
//
// Handshake: key_valid/key_code is a valid-only strobe with no ready. A key
// event is presented for exactly one clk cycle with key_valid=1 and the
// code on key_code; the consumer must take it in that cycle. Outside the
// strobe key_code is KEY_NONE and key_valid is 0, so the two never disagree.
//
// master : the scanner (drives columns, code, strobe, state; reads rows)
// slave  : the keypad/consumer side
interface keypad_scanner_if;
  import safe_pkg::*;

  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  scan_state_t state;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output state
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  state
  );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the 4 raw keypad rows.
//   clk : system clock
//   rst : asynchronous active-high reset; presets both stages to all-ones,
//         which is the "no key pressed" level of the pulled-up rows
//   d   : raw asynchronous row inputs
//   q   : synchronised rows (second flop)
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3-column x 4-row matrix keypad scanner with debounce.
// Drives one column low at a time, samples the synchronised rows at the end
// of each column dwell, debounces a single-key press, issues exactly one
// key code strobe per press and then waits for a debounced release.
//   clk : system clock
//   rst : asynchronous active-high reset
//   kp  : keypad_scanner_if master (row_n in; col_n, key_code, key_valid,
//         state out)
// Parameters:
//   SCAN_DIV        : cycles each column is held before its rows are sampled
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept press/release
module keypad_scanner
  import safe_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DWELL_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Synchronised rows; every decision below uses row_s only.
  logic [3:0] row_s;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.row_n),
    .q   (row_s)
  );

  scan_state_t   state_q,    state_d;
  logic [1:0]    col_q,      col_d;
  logic [1:0]    row_q,      row_d;
  logic [CW-1:0] dwell_q,    dwell_d;
  logic [CW-1:0] stable_q,   stable_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;

  // Row pattern decode: a press is only accepted when exactly one row is
  // low. Zero or several low rows (multi-press or ghosting) are ignored.
  logic       one_low;
  logic [1:0] low_idx;

  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (row_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // One-low pattern of the latched row; debounce compares against it.
  logic [3:0] held_pattern;
  assign held_pattern = ~(4'b0001 << row_q);

  // Column rotation 0 -> 1 -> 2 -> 0.
  logic [1:0] col_next;
  assign col_next = (col_q >= 2'd2) ? 2'd0 : col_q + 2'd1;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    stable_d    = stable_q;
    key_code_d  = KEY_NONE;
    key_valid_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            // Hold the current column and start debouncing this key.
            row_d    = low_idx;
            stable_d = '0;
            state_d  = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (row_s == held_pattern) begin
          if (stable_q == STABLE_LAST) begin
            state_d = EMIT;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end else begin
          // Bounce or glitch: drop the candidate silently.
          col_d    = col_next;
          dwell_d  = '0;
          stable_d = '0;
          state_d  = SCAN;
        end
      end

      EMIT: begin
        key_code_d  = key_map(row_q, col_q);
        key_valid_d = 1'b1;
        stable_d    = '0;
        state_d     = RELEASE;
      end

      RELEASE: begin
        // Column stays held so a key kept down keeps the row low and can
        // never produce a second code.
        if (row_s == 4'b1111) begin
          if (stable_q == STABLE_LAST) begin
            col_d    = col_next;
            dwell_d  = '0;
            stable_d = '0;
            state_d  = SCAN;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end else begin
          stable_d = '0;
        end
      end

      default: begin
        col_d    = 2'd0;
        dwell_d  = '0;
        stable_d = '0;
        state_d  = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      stable_q    <= '0;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      stable_q    <= stable_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Column drive decoded straight from the column register.
  logic [2:0] col_n_dec;

  always_comb begin
    case (col_q)
      2'd0:    col_n_dec = 3'b110;
      2'd1:    col_n_dec = 3'b101;
      2'd2:    col_n_dec = 3'b011;
      default: col_n_dec = 3'b110;
    endcase
  end

  assign kp.col_n     = col_n_dec;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.state     = state_q;

endmodule
